kf_cov_arb: RTL and testbench
=============================

KF_COV_ARB -- requirements
Module: kf_cov_arb

Interface
REQ-001 SHALL have parameter N, default `FXP_N, fixed-point word width.
REQ-002 SHALL have parameter FRAC, default `FXP_FRAC, fractional bits.
REQ-003 SHALL have parameter TIMEOUT, default 16, watchdog limit in cycles (used only when KF_ARB_TIMEOUT_EN is defined).
REQ-004 SHALL have port: clk  input  1  system clock; one clock domain only.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: req0, req1  input  1  per-channel request, held until that channel's ack.
REQ-007 SHALL have ports: a0, p0, q0, a1, p1, q1  input  4*N  packed 2x2 operand matrices {m11,m10,m01,m00}, signed.
REQ-008 SHALL have ports: ack0, ack1  output  1  one-cycle pulse; operands captured.
REQ-009 SHALL have ports: rsp_valid0, rsp_valid1  output  1  one-cycle pulse; p_out is valid for that channel.
REQ-010 SHALL have port: p_out  output  4*N  P_prior result, same packing as REQ-007.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: err  output  1  sticky watchdog flag.

Function
REQ-013 SHALL share one prior_cov_semipar instance (P = A*P*A^T + Q) between channels 0 and 1.
REQ-014 SHALL implement FSM IDLE->LAUNCH->WAIT->RESP->IDLE.
REQ-015 IDLE, at least one req high at a clock edge: SHALL grant one channel, latch its a/p/q into operand registers, go to LAUNCH.
REQ-016 Arbitration SHALL be round-robin: with both requests high, grant the channel not granted last; with one request high, grant it.
REQ-017 In LAUNCH, ack of the granted channel and engine start SHALL be high for exactly that one cycle; the engine SHALL see only the latched operands.
REQ-018 In WAIT, the first cycle with engine done high SHALL register engine P_PRIOR into p_out and move to RESP.
REQ-019 In RESP, rsp_valid of the granted channel SHALL be high for one cycle, then the FSM SHALL return to IDLE.
REQ-020 Total latency SHALL be: rsp_valid asserts exactly 2 cycles after the cycle in which done is first sampled high.
REQ-021 No request SHALL be accepted outside IDLE; requests arriving in any other state remain pending.
REQ-022 A request in the same edge as a RESP->IDLE transition SHALL be evaluated on the next edge.
REQ-023 p_out SHALL hold its last value until the next result; arithmetic and widths SHALL be the engine's, unmodified.
REQ-024 Requester-side handshake violations (req dropped before ack) SHALL be ignored if the drop occurs before grant; operands already latched remain in use.

Reset
REQ-025 rst high SHALL asynchronously force: state IDLE; ack*, rsp_valid*, busy, err = 0; p_out = 0; operand registers = 0; last-grant = 1, so channel 0 wins first.
REQ-026 The engine reset SHALL be driven by ~rst; reset mid-operation SHALL abandon the job with no rsp_valid.

Configuration
REQ-027 With KF_ARB_TIMEOUT_EN defined: a WAIT-state counter SHALL, after TIMEOUT cycles without done, set err and go to RESP with p_out = 0, still pulsing rsp_valid.
REQ-028 Without KF_ARB_TIMEOUT_EN: WAIT SHALL persist until done, and err SHALL be tied to 0.

Structure
REQ-029 FXP_N and FXP_FRAC SHALL come from shared fxp_types.vh; FSM state encodings and the packing macro SHALL live in the shared kf_pkg.
REQ-030 The sole sub-module SHALL be prior_cov_semipar; all arbitration and FSM logic SHALL stay inline.

Verification
REQ-031 req0 only, A=I, P=I, Q=0.25I (S=1<<FRAC) -> ack0 pulse; rsp_valid0 with p_out diag = S+(S>>2), off-diagonal = 0; rsp_valid0 8+2 cycles after start.
REQ-032 req0 and req1 asserted same edge after reset -> channel 0 served first, then channel 1; exactly one ack and one rsp_valid per channel.
REQ-033 Both held high for 4 jobs -> grants alternate 0,1,0,1.
REQ-034 req1 raised during channel-0 WAIT with Q1=0.5I -> accepted only after rsp_valid0; p_out diag = S+(S>>1).
REQ-035 rst pulsed in WAIT -> no rsp_valid, busy=0 immediately, next req0 completes correctly.
REQ-036 KF_ARB_TIMEOUT_EN defined, engine done forced low -> err=1 and rsp_valid0 with p_out=0 after TIMEOUT=16 cycles; err stays 1 until rst.

Source files
------------

// File: rtl/kf_pkg.sv
// kf_pkg: shared Kalman-filter definitions (fixed-point defaults from
// fxp_types, arbiter FSM encodings, 2x2 matrix packing macro).
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif
`ifndef KF_PACK
`define KF_PACK(m11, m10, m01, m00) {m11, m10, m01, m00}
`endif

package kf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // engine cycles from start to done
  localparam int ENG_STEPS = 8;

endpackage

// File: rtl/kf_cov_arb_if.sv
// kf_cov_arb_if: start/done job bus between the arbiter and the
// shared prior-covariance engine.
`ifndef FXP_N
`define FXP_N 16
`endif

interface kf_cov_arb_if #(
  parameter int N = `FXP_N
);
  logic           start;
  logic           done;
  logic [4*N-1:0] a;
  logic [4*N-1:0] p;
  logic [4*N-1:0] q;
  logic [4*N-1:0] p_prior;

  modport master (
    output start, a, p, q,
    input  done, p_prior
  );

  modport slave (
    input  start, a, p, q,
    output done, p_prior
  );
endinterface

// File: rtl/prior_cov_semipar.sv
// prior_cov_semipar: P = A*P*A^T + Q on 2x2 signed fixed-point
// matrices, two multipliers, one element per cycle (8 cycles to done).
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif
`ifndef KF_PACK
`define KF_PACK(m11, m10, m01, m00) {m11, m10, m01, m00}
`endif

module prior_cov_semipar
  import kf_pkg::*;
#(
  parameter int N    = `FXP_N,
  parameter int FRAC = `FXP_FRAC
) (
  input logic         clk,
  input logic         rst_n,
  kf_cov_arb_if.slave bus
);

  logic                  run;
  logic                  done;
  logic [2:0]            step;
  logic [2:0]            idx;
  logic                  i;
  logic                  j;
  logic signed [N-1:0]   am [4];
  logic signed [N-1:0]   pm [4];
  logic signed [N-1:0]   qm [4];
  logic signed [N-1:0]   mm [4];
  logic signed [N-1:0]   rm [4];
  logic signed [N-1:0]   x0, y0, x1, y1;
  logic signed [2*N-1:0] pr0, pr1;
  logic signed [2*N:0]   sum;
  logic [N-1:0]          val;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      am[k] = bus.a[k*N +: N];
      pm[k] = bus.p[k*N +: N];
      qm[k] = bus.q[k*N +: N];
    end
  end

  // first element is computed in the start cycle itself
  assign idx = bus.start ? 3'd0 : step;
  assign i   = idx[1];
  assign j   = idx[0];

  // steps 0-3: M = A*P ; steps 4-7: R = M*A^T + Q
  always_comb begin
    if (!idx[2]) begin
      x0 = am[{i, 1'b0}];
      y0 = pm[{1'b0, j}];
      x1 = am[{i, 1'b1}];
      y1 = pm[{1'b1, j}];
    end else begin
      x0 = mm[{i, 1'b0}];
      y0 = am[{j, 1'b0}];
      x1 = mm[{i, 1'b1}];
      y1 = am[{j, 1'b1}];
    end
  end

  assign pr0 = (2*N)'(x0) * (2*N)'(y0);
  assign pr1 = (2*N)'(x1) * (2*N)'(y1);
  assign sum = (2*N+1)'(pr0) + (2*N+1)'(pr1);
  assign val = N'(sum >>> FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      step <= '0;
      done <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        mm[k] <= '0;
        rm[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (bus.start || run) begin
        if (idx[2]) rm[idx[1:0]] <= val + qm[idx[1:0]];
        else        mm[idx[1:0]] <= val;
        if (idx == 3'(ENG_STEPS-1)) begin
          run  <= 1'b0;
          step <= '0;
          done <= 1'b1;
        end else begin
          run  <= 1'b1;
          step <= idx + 3'd1;
        end
      end
    end
  end

  assign bus.done    = done;
  assign bus.p_prior = `KF_PACK(rm[3], rm[2], rm[1], rm[0]);

endmodule

// File: rtl/kf_cov_arb.sv
// kf_cov_arb: round-robin sharing of one prior_cov_semipar between two
// requesters. Define KF_ARB_TIMEOUT_EN to enable the WAIT watchdog.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module kf_cov_arb
  import kf_pkg::*;
#(
  parameter int N       = `FXP_N,
  parameter int FRAC    = `FXP_FRAC,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [4*N-1:0] a0,
  input  logic [4*N-1:0] p0,
  input  logic [4*N-1:0] q0,
  input  logic [4*N-1:0] a1,
  input  logic [4*N-1:0] p1,
  input  logic [4*N-1:0] q1,
  output logic           ack0,
  output logic           ack1,
  output logic           rsp_valid0,
  output logic           rsp_valid1,
  output logic [4*N-1:0] p_out,
  output logic           busy,
  output logic           err
);

  arb_state_e     state;
  logic           last;
  logic           gnt;
  logic           pick;
  logic           start;
  logic [4*N-1:0] a_r;
  logic [4*N-1:0] p_r;
  logic [4*N-1:0] q_r;

  kf_cov_arb_if #(.N(N)) eng_bus ();

  assign eng_bus.start = start;
  assign eng_bus.a     = a_r;
  assign eng_bus.p     = p_r;
  assign eng_bus.q     = q_r;

  prior_cov_semipar #(
    .N   (N),
    .FRAC(FRAC)
  ) u_eng (
    .clk  (clk),
    .rst_n(~rst),
    .bus  (eng_bus.slave)
  );

  // contention goes to the channel not served last
  assign pick = (req0 && req1) ? ~last : req1;

`ifdef KF_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      gnt        <= 1'b0;
      start      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      busy       <= 1'b0;
      p_out      <= '0;
      a_r        <= '0;
      p_r        <= '0;
      q_r        <= '0;
`ifdef KF_ARB_TIMEOUT_EN
      wdog       <= '0;
      err        <= 1'b0;
`endif
    end else begin
      start      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            gnt   <= pick;
            last  <= pick;
            a_r   <= pick ? a1 : a0;
            p_r   <= pick ? p1 : p0;
            q_r   <= pick ? q1 : q0;
            ack0  <= ~pick;
            ack1  <= pick;
            start <= 1'b1;
            busy  <= 1'b1;
            state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
`ifdef KF_ARB_TIMEOUT_EN
          wdog  <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_bus.done) begin
            p_out <= eng_bus.p_prior;
            state <= ST_RESP;
          end
`ifdef KF_ARB_TIMEOUT_EN
          else if (wdog == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            p_out <= '0;
            state <= ST_RESP;
          end else begin
            wdog  <= wdog + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          rsp_valid0 <= ~gnt;
          rsp_valid1 <= gnt;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_cov_arb.sv
// tb_kf_cov_arb: directed jobs with a queue-based scoreboard; a monitor
// checks grant order, results and ack-to-response latency.
module tb_kf_cov_arb;

  localparam int N       = 16;
  localparam int FRAC    = 8;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 10;
  localparam logic [N-1:0] S = 16'h0100;

  typedef struct packed {
    logic           ch;
    logic [4*N-1:0] data;
    logic [7:0]     lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [4*N-1:0] a0 = '0, p0 = '0, q0 = '0;
  logic [4*N-1:0] a1 = '0, p1 = '0, q1 = '0;
  logic ack0, ack1, rsp_valid0, rsp_valid1, busy, err;
  logic [4*N-1:0] p_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc [2];
  int rsp_cyc [2];
  bit   exp_ack [$];
  rsp_t exp_rsp [$];

  kf_cov_arb #(
    .N(N), .FRAC(FRAC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .p0(p0), .q0(q0), .a1(a1), .p1(p1), .q1(q1),
    .ack0(ack0), .ack1(ack1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .p_out(p_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*N-1:0] mk(
    input logic [N-1:0] m11, m10, m01, m00);
    return {m11, m10, m01, m00};
  endfunction

  function automatic logic [4*N-1:0] dg(input logic [N-1:0] v);
    return mk(v, '0, '0, v);
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit ch, input logic [4*N-1:0] d,
                      input int lat);
    rsp_t e;
    e.ch = ch;
    e.data = d;
    e.lat = 8'(lat);
    exp_ack.push_back(ch);
    exp_rsp.push_back(e);
  endtask

  task automatic wait_ack(input bit ch, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ch ? ack1 : ack0) && n < budget);
    checks++;
    if (!(ch ? ack1 : ack0)) begin
      errors++;
      $display("FAIL ack_wait ch%0d: no ack after %0d cycles", ch, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_rsp.size() != 0) && n < budget);
    checks++;
    if (busy || exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL idle_wait: busy=%0b pending=%0d", busy,
               exp_rsp.size());
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0 || ack1) begin
        chk("ack_onehot", {ack0, ack1}, 2'b10 >> ack1);
        if (exp_ack.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: got ack%0d expected none", ack1);
        end else begin
          chk("ack_chan", ack1, exp_ack.pop_front());
        end
        ack_cyc[ack1] = cyc;
      end
      if (rsp_valid0 || rsp_valid1) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp%0d p_out=%h expected none",
                   rsp_valid1, p_out);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_chan", {rsp_valid1, rsp_valid0},
              e.ch ? 2'b10 : 2'b01);
          chk("p_out", p_out, e.data);
          chk("latency", cyc - ack_cyc[e.ch], e.lat);
        end
        rsp_cyc[rsp_valid1] = cyc;
      end
    end
  end

  initial begin
    logic [4*N-1:0] eye;
    int acks;
    eye = dg(S);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {ack0, ack1}, 0);
    chk("rst_rsp", {rsp_valid0, rsp_valid1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_p_out", p_out, 0);

    // single job: A=I, P=I, Q=0.25I
    a0 = eye; p0 = eye; q0 = dg(S >> 2);
    push(0, dg(S + (S >> 2)), LAT);
    req0 = 1'b1;
    wait_ack(0, 20);
    chk("busy_launch", busy, 1);
    req0 = 1'b0;
    wait_idle(60);

    // both on the same edge after reset: ch0 then ch1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a1 = dg(2 * S); p1 = eye; q1 = '0;
    push(0, dg(S + (S >> 2)), LAT);
    push(1, dg(4 * S), LAT);
    req0 = 1'b1;
    req1 = 1'b1;
    wait_ack(0, 20);
    req0 = 1'b0;
    wait_ack(1, 40);
    req1 = 1'b0;
    wait_idle(60);

    // both held for four jobs: grants 0,1,0,1
    p0 = dg(2 * S);
    a1 = mk(S, '0, S, S); p1 = eye; q1 = '0;
    for (int k = 0; k < 2; k++) begin
      push(0, dg(2 * S + (S >> 2)), LAT);
      push(1, mk(S, S, S, 2 * S), LAT);
    end
    req0 = 1'b1;
    req1 = 1'b1;
    acks = 0;
    for (int n = 0; n < 120 && acks < 4; n++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("four_grants", acks, 4);
    wait_idle(60);

    // req1 raised during ch0 WAIT; signed operands on ch0
    a0 = dg(16'hFF00); p0 = eye; q0 = dg(16'hFFC0);
    a1 = eye; p1 = eye; q1 = dg(S >> 1);
    push(0, dg(16'h00C0), LAT);
    push(1, dg(S + (S >> 1)), LAT);
    rsp_cyc[0] = -100;
    req0 = 1'b1;
    wait_ack(0, 20);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_wait", busy, 1);
    req1 = 1'b1;
    wait_ack(1, 40);
    chk("ack1_after_rsp0", cyc - rsp_cyc[0], 1);
    req1 = 1'b0;
    wait_idle(60);

    // reset in WAIT abandons the job
    a0 = dg(2 * S); p0 = eye; q0 = '0;
    exp_ack.push_back(1'b0);
    req0 = 1'b1;
    wait_ack(0, 20);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp", {rsp_valid0, rsp_valid1}, 0);
    chk("abort_p_out", p_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    a0 = eye; p0 = eye; q0 = dg(S >> 2);
    a1 = mk(S, '0, S, S); p1 = eye; q1 = '0;
    push(0, dg(S + (S >> 2)), LAT);
    push(1, mk(S, S, S, 2 * S), LAT);
    req0 = 1'b1;
    req1 = 1'b1;
    wait_ack(0, 20);
    req0 = 1'b0;
    wait_ack(1, 40);
    req1 = 1'b0;
    wait_idle(60);

`ifdef KF_ARB_TIMEOUT_EN
    // engine done held low: watchdog answers with zero
    force dut.eng_bus.done = 1'b0;
    push(0, '0, TIMEOUT + 2);
    req0 = 1'b1;
    wait_ack(0, 20);
    req0 = 1'b0;
    wait_idle(80);
    chk("err_set", err, 1);
    release dut.eng_bus.done;
    push(0, dg(S + (S >> 2)), LAT);
    req0 = 1'b1;
    wait_ack(0, 20);
    req0 = 1'b0;
    wait_idle(60);
    chk("err_sticky", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);
`else
    chk("err_tied", err, 0);
`endif

    chk("ack_queue_empty", exp_ack.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
